// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encoding and scoreboard entry layout.
// The forwarding constants and entry type are also used by the CPU datapath operand muxes.
package pipe_pkg;

    localparam int unsigned REG_AW = 5;

    // Operand-select encoding for the ID/EX forwarding muxes
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } sb_entry_t;

    // An entry produces r when it will write r; register 0 is never produced.
    function automatic logic produces(input sb_entry_t e, input logic [REG_AW-1:0] r);
        return e.valid && e.wreg && (e.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority match of one source operand against the EX/MEM/WB scoreboard entries.
// Produces the forwarding select and a load-use flag for that operand.
module hazard_fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_src_i,
    input  sb_entry_t         ex_i,
    input  sb_entry_t         mem_i,
    input  sb_entry_t         wb_i,
    output logic [1:0]        fwd_o,
    output logic              load_use_o
);

    // Youngest producer wins; a load still in EX cannot forward yet
    always_comb begin
        fwd_o      = FWD_RF;
        load_use_o = 1'b0;
        if (use_src_i) begin
            if (produces(ex_i, src_i)) begin
                fwd_o      = FWD_EX;
                load_use_o = ex_i.is_load;
            end else if (produces(mem_i, src_i)) begin
                fwd_o = FWD_MEM;
            end else if (produces(wb_i, src_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Data-hazard resolution unit beside the ID stage: tracks in-flight destinations in
// EX/MEM/WB, drives operand forwarding selects and a one-cycle load-use stall.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic [AW-1:0] id_rd,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNTW-1:0] stall_cnt
`endif
);

    // Entry layout in the package fixes the register-address width
    if (AW != REG_AW) begin : g_aw_check
        $error("pipe_hazard_scoreboard: AW must equal pipe_pkg::REG_AW");
    end
    if (CNTW < 1) begin : g_cntw_check
        $error("pipe_hazard_scoreboard: CNTW must be at least 1");
    end

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d, mem_d, wb_d;
    logic      lu_a, lu_b;

    hazard_fwd_sel u_sel_rs (
        .src_i      (id_rs),
        .use_src_i  (id_valid & id_use_rs),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .fwd_o      (fwd_a),
        .load_use_o (lu_a)
    );

    hazard_fwd_sel u_sel_rt (
        .src_i      (id_rt),
        .use_src_i  (id_valid & id_use_rt),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .fwd_o      (fwd_b),
        .load_use_o (lu_b)
    );

    // Flush squashes the ID instruction, so it can never cause a stall
    assign stall = (lu_a | lu_b) & ~flush;

    // Scoreboard always advances; only ID insertion is replaced by a bubble
    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid   = 1'b1;
            ex_d.wreg    = id_wreg;
            ex_d.rd      = id_rd;
            ex_d.is_load = id_is_load;
        end
    end

    // Entry pipeline; reset discards everything in flight
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: reset, ALU forwarding chain, load-use,
// priority, $0, flush, mid-run reset and (with HAZARD_STALL_CNT_EN) counter saturation.
module tb_pipe_hazard_scoreboard;

    localparam int unsigned AW   = 5;
    localparam int unsigned CNTW = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_use_rs, id_use_rt, id_wreg, id_is_load, flush;
    logic          stall;
    logic [1:0]    fwd_a, fwd_b;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(
        .AW   (AW),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wreg    (id_wreg),
        .id_rd      (id_rd),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Drive one ID-stage instruction at the falling edge, settle before checking
    task automatic issue(input logic v, input int rs, input logic urs, input int rt,
                         input logic urt, input logic w, input int rd, input logic ld,
                         input logic fl);
        @(negedge clk);
        id_valid   = v;
        id_rs      = AW'(rs);
        id_use_rs  = urs;
        id_rt      = AW'(rt);
        id_use_rt  = urt;
        id_wreg    = w;
        id_rd      = AW'(rd);
        id_is_load = ld;
        flush      = fl;
        #1;
    endtask

    task automatic chk(input string tag, input logic s, input logic [1:0] a,
                       input logic [1:0] b);
        checks++;
        assert (stall === s && fwd_a === a && fwd_b === b) else begin
            errors++;
            $error("FAIL %s: stall/fwd_a/fwd_b got %b/%0d/%0d expected %b/%0d/%0d",
                   tag, stall, fwd_a, fwd_b, s, a, b);
        end
    endtask

`ifdef HAZARD_STALL_CNT_EN
    task automatic chk_cnt(input string tag, input logic [CNTW-1:0] exp);
        checks++;
        assert (stall_cnt === exp) else begin
            errors++;
            $error("FAIL %s: stall_cnt got %0d expected %0d", tag, stall_cnt, exp);
        end
    endtask
`endif

    initial begin
        clrn = 1'b0;
        {id_valid, id_use_rs, id_use_rt, id_wreg, id_is_load, flush} = '0;
        id_rs = '0;
        id_rt = '0;
        id_rd = '0;

        // Reset held with random ID inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {id_valid, id_use_rs, id_use_rt, id_wreg, id_is_load} = 5'($urandom);
            id_rs = AW'($urandom);
            id_rt = AW'($urandom);
            id_rd = AW'($urandom);
            flush = 1'b0;
            #1;
            chk("reset_hold", 1'b0, 2'd0, 2'd0);
        end
`ifdef HAZARD_STALL_CNT_EN
        chk_cnt("reset_cnt", 4'd0);
`endif
        @(negedge clk);
        id_valid = 1'b0;
        clrn     = 1'b1;

        // ALU chain on $3
        issue(1, 1, 1, 2, 1, 1, 3, 0, 0);   // add $3,$1,$2
        chk("lone_add", 1'b0, 2'd0, 2'd0);
        issue(1, 3, 1, 5, 1, 1, 4, 0, 0);   // sub $4,$3,$5
        chk("alu_fwd_ex", 1'b0, 2'd1, 2'd0);
        issue(1, 3, 1, 0, 1, 1, 6, 0, 0);   // or $6,$3,$0
        chk("alu_fwd_mem", 1'b0, 2'd2, 2'd0);
        issue(1, 7, 1, 3, 1, 1, 10, 0, 0);  // reader of $3 on rt
        chk("alu_fwd_wb", 1'b0, 2'd0, 2'd3);
        issue(1, 3, 1, 3, 1, 1, 11, 0, 0);
        chk("alu_fwd_gone", 1'b0, 2'd0, 2'd0);

        // Load-use on $8
        issue(1, 1, 1, 0, 0, 1, 8, 1, 0);   // lw $8
        chk("lw_issue", 1'b0, 2'd0, 2'd0);
        issue(1, 8, 1, 8, 1, 1, 9, 0, 0);   // add $9,$8,$8
        chk("load_use_stall", 1'b1, 2'd1, 2'd1);
        issue(1, 8, 1, 8, 1, 1, 9, 0, 0);   // held consumer
        chk("load_use_resume", 1'b0, 2'd2, 2'd2);
`ifdef HAZARD_STALL_CNT_EN
        chk_cnt("cnt_one", 4'd1);
`endif
        issue(1, 9, 1, 0, 0, 0, 0, 0, 0);   // reader of $9
        chk("consumer_inserted", 1'b0, 2'd1, 2'd0);
        issue(0, 9, 1, 9, 1, 0, 0, 0, 0);   // invalid ID gates all matches
        chk("id_invalid", 1'b0, 2'd0, 2'd0);

        // Priority EX over MEM, and $0
        issue(1, 1, 1, 2, 1, 1, 3, 0, 0);   // add $3
        chk("prio_add", 1'b0, 2'd0, 2'd0);
        issue(1, 3, 1, 4, 1, 1, 3, 0, 0);   // or $3,$3,$4
        chk("prio_or", 1'b0, 2'd1, 2'd0);
        issue(1, 3, 1, 3, 1, 0, 0, 0, 0);
        chk("prio_ex_wins", 1'b0, 2'd1, 2'd1);
        issue(1, 0, 1, 0, 1, 1, 0, 1, 0);   // load writing $0
        chk("zero_writer", 1'b0, 2'd0, 2'd0);
        issue(1, 0, 1, 0, 1, 0, 0, 0, 0);   // reader of $0
        chk("zero_reader", 1'b0, 2'd0, 2'd0);

        // Flush beats load-use
        issue(1, 1, 1, 0, 0, 1, 12, 1, 0);  // lw $12
        chk("flush_lw", 1'b0, 2'd0, 2'd0);
        issue(1, 12, 1, 12, 1, 1, 13, 0, 1); // add $13,$12,$12 flushed
        chk("flush_no_stall", 1'b0, 2'd1, 2'd1);
        issue(1, 13, 1, 12, 1, 0, 0, 0, 0);
        chk("flush_bubble", 1'b0, 2'd0, 2'd2);
        issue(1, 13, 1, 13, 1, 0, 0, 0, 0);
        chk("flush_no_fwd", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_STALL_CNT_EN
        chk_cnt("cnt_flush", 4'd1);
`endif

        // Async reset in the middle of a load-use
        issue(1, 1, 1, 0, 0, 1, 14, 1, 0);  // lw $14
        issue(1, 14, 1, 0, 0, 1, 15, 0, 0);
        chk("pre_reset_stall", 1'b1, 2'd1, 2'd0);
        #1 clrn = 1'b0;
        #1;
        chk("async_reset", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_STALL_CNT_EN
        chk_cnt("async_reset_cnt", 4'd0);
`endif
        @(negedge clk);
        id_valid = 1'b0;
        clrn     = 1'b1;
        issue(1, 14, 1, 14, 1, 0, 0, 0, 0);
        chk("reset_discards", 1'b0, 2'd0, 2'd0);

        // 20 load-use stalls
        for (int i = 0; i < 20; i++) begin
            issue(1, 1, 1, 0, 0, 1, 8, 1, 0);
            issue(1, 8, 1, 0, 0, 1, 9, 0, 0);
            chk("sat_stall", 1'b1, 2'd1, 2'd0);
            issue(1, 8, 1, 0, 0, 1, 9, 0, 0);
        end
`ifdef HAZARD_STALL_CNT_EN
        chk_cnt("cnt_saturated", 4'd15);
        issue(1, 1, 1, 0, 0, 1, 8, 1, 0);
        issue(1, 8, 1, 0, 0, 1, 9, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_cnt("cnt_holds", 4'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
